// File: rtl/vc_input_buffer.sv
// Router input stage: one FIFO per virtual channel with per-VC ready, and a
// strict-priority output that locks onto a VC for the length of a packet.
module vc_input_buffer #(
  parameter int NUM_VC     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int FLIT_W     = 34,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc_id,
  input  logic [FLIT_W-1:0] in_fdata,
  output logic [NUM_VC-1:0] in_ready,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc_id,
  output logic [FLIT_W-1:0] out_fdata,
  input  logic              out_ready,
  output logic              overflow_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b10;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [FLIT_W-1:0] mem    [NUM_VC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  count  [NUM_VC];

  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] push_vec;
  logic [NUM_VC-1:0] pop_vec;
  logic              push_ok;

  state_t            state;
  logic [VC_W-1:0]   lock_vc;
  logic              hold;
  logic [VC_W-1:0]   sel_q;
  logic [VC_W-1:0]   last_vc;

  logic [VC_W-1:0]   hi_vc;
  logic [VC_W-1:0]   sel;
  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic              xfer;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v] = (count[v] == '0);
      full[v]  = (count[v] == CNT_W'(FIFO_DEPTH));
    end
  end

  // Ready comes only from occupancy, so a full FIFO refuses a push even if it pops this cycle.
  assign in_ready = rst ? '0 : ~full;

  // An out-of-range VC id matches no FIFO and therefore counts as refused.
  always_comb begin
    push_ok  = 1'b0;
    push_vec = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_vc_id == VC_W'(v)) begin
        push_vec[v] = in_valid && in_ready[v];
        push_ok     = in_valid && in_ready[v];
      end
    end
  end

  always_comb begin
    hi_vc = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (!empty[v]) hi_vc = VC_W'(v);
    end
  end

  // A stalled presentation keeps its VC; otherwise a locked packet owns the output.
  always_comb begin
    if (hold) begin
      sel       = sel_q;
      out_valid = !empty[sel_q];
    end else if (state == LOCKED) begin
      sel       = lock_vc;
      out_valid = !empty[lock_vc];
    end else begin
      sel       = hi_vc;
      out_valid = |(~empty);
    end
  end

  always_comb begin
    head = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (sel == VC_W'(v)) head = mem[v][rd_ptr[v]];
    end
  end

  assign head_type = head[FLIT_W-1 -: 2];
  assign xfer      = out_valid && out_ready;
  assign out_fdata = out_valid ? head : '0;
  assign out_vc_id = out_valid ? sel : last_vc;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      pop_vec[v] = xfer && (sel == VC_W'(v));
    end
  end

  // Flit storage: data only, never reset.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_vec[v]) mem[v][wr_ptr[v]] <= in_fdata;
    end
  end

  // Control: pointers, occupancy, wormhole FSM, hold flag and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      state        <= IDLE;
      lock_vc      <= '0;
      hold         <= 1'b0;
      sel_q        <= '0;
      last_vc      <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_vec[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop_vec[v])  rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        count[v] <= count[v] + CNT_W'(push_vec[v]) - CNT_W'(pop_vec[v]);
      end

      if (in_valid && !push_ok) overflow_err <= 1'b1;
      if (out_valid) last_vc <= sel;

      if (xfer) begin
        hold <= 1'b0;
      end else if (out_valid) begin
        hold  <= 1'b1;
        sel_q <= sel;
      end

      if (xfer) begin
        case (state)
          IDLE: begin
            if (head_type == FT_HEAD) begin
              state   <= LOCKED;
              lock_vc <= sel;
            end
          end
          LOCKED: begin
            if (head_type == FT_TAIL) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: directed scenarios plus random traffic, all
// checked against a queue-based packet model of the input stage.
module tb_vc_input_buffer;

  localparam int NUM_VC     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FLIT_W     = 34;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [1:0]        in_vc_id = '0;
  logic [FLIT_W-1:0] in_fdata = '0;
  logic [NUM_VC-1:0] in_ready;
  logic              out_valid;
  logic [1:0]        out_vc_id;
  logic [FLIT_W-1:0] out_fdata;
  logic              out_ready = 1'b0;
  logic              overflow_err;

  vc_input_buffer #(
    .NUM_VC(NUM_VC), .FIFO_DEPTH(FIFO_DEPTH), .FLIT_W(FLIT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vc_id(in_vc_id), .in_fdata(in_fdata), .in_ready(in_ready),
    .out_valid(out_valid), .out_vc_id(out_vc_id), .out_fdata(out_fdata), .out_ready(out_ready),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: packet queues per VC plus the output ownership rules.
  logic [FLIT_W-1:0] q [NUM_VC][$];
  int lock_vc = -1;
  int hold_vc = -1;
  int last_vc = 0;
  bit ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_sel(output bit v, output int s);
    if (hold_vc >= 0) s = hold_vc;
    else if (lock_vc >= 0) s = lock_vc;
    else begin
      s = 0;
      for (int i = 0; i < NUM_VC; i++) if (q[i].size() > 0) s = i;
    end
    v = (q[s].size() > 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_VC; i++) q[i].delete();
    lock_vc = -1;
    hold_vc = -1;
    last_vc = 0;
    ovf     = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit iv, input int ivc, input logic [FLIT_W-1:0] idat, input bit ordy);
    bit v;
    int s;
    bit do_push;
    logic [NUM_VC-1:0] erdy;
    logic [FLIT_W-1:0] f;
    in_valid  = iv;
    in_vc_id  = 2'(ivc);
    in_fdata  = idat;
    out_ready = ordy;
    #1;
    model_sel(v, s);
    for (int i = 0; i < NUM_VC; i++) erdy[i] = (q[i].size() < FIFO_DEPTH);
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_vc_id", 64'(out_vc_id), 64'(v ? s : last_vc));
    if (v) chk("out_fdata", 64'(out_fdata), 64'(q[s][0]));
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("overflow_err", 64'(overflow_err), 64'(ovf));

    do_push = 1'b0;
    if (iv) begin
      if (ivc < NUM_VC && q[ivc].size() < FIFO_DEPTH) do_push = 1'b1;
      else ovf = 1'b1;
    end
    if (v && ordy) begin
      f = q[s].pop_front();
      if (lock_vc < 0) begin
        if (f[FLIT_W-1 -: 2] == HEAD) lock_vc = s;
      end else if (f[FLIT_W-1 -: 2] == TAIL) begin
        lock_vc = -1;
      end
      hold_vc = -1;
    end else if (v) begin
      hold_vc = s;
    end
    if (v) last_vc = s;
    if (do_push) q[ivc].push_back(idat);

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 0, '0, ordy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready_low", 64'(in_ready), 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_vc_id", 64'(out_vc_id), 64'h0);
    chk("rst_out_fdata", 64'(out_fdata), 64'h0);
    chk("rst_overflow", 64'(overflow_err), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'h7);
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single HEAD_TAIL on VC1: visible one cycle after the push, then popped.
    cycle(1, 1, 34'h3_0000_0001, 0);
    chk("ht_valid", 64'(out_valid), 64'h1);
    chk("ht_vc", 64'(out_vc_id), 64'h1);
    chk("ht_data", 64'(out_fdata), 64'h3_0000_0001);
    idle(1);
    chk("ht_popped", 64'(out_valid), 64'h0);

    // Fill VC0, overflow it, then drain in order.
    for (int i = 0; i < FIFO_DEPTH; i++) cycle(1, 0, mk(HT, 32'hA00 + i), 0);
    chk("full_in_ready", 64'(in_ready), 64'h6);
    cycle(1, 0, mk(HT, 32'hBAD), 0);
    chk("ovf_set", 64'(overflow_err), 64'h1);
    chk("ovf_head", 64'(out_fdata), 64'(mk(HT, 32'hA00)));
    for (int i = 0; i < FIFO_DEPTH; i++) idle(1);
    chk("ovf_sticky", 64'(overflow_err), 64'h1);
    chk("drained", 64'(out_valid), 64'h0);
    do_reset();

    // Priority: while VC1 holds a lock, VC0 and VC2 queue up; VC2 wins after release.
    cycle(1, 1, mk(HEAD, 32'h100), 1);
    cycle(1, 0, mk(HT, 32'h200), 1);
    cycle(1, 2, mk(HT, 32'h300), 1);
    chk("lock_stall", 64'(out_valid), 64'h0);
    cycle(1, 1, mk(TAIL, 32'h101), 1);
    idle(1);
    chk("prio_first_vc", 64'(out_vc_id), 64'h2);
    chk("prio_first_data", 64'(out_fdata), 64'(mk(HT, 32'h300)));
    idle(1);
    chk("prio_second_vc", 64'(out_vc_id), 64'h0);
    idle(1);
    chk("prio_empty", 64'(out_valid), 64'h0);

    // Wormhole lock on VC0 while VC2 waits.
    cycle(1, 0, mk(HEAD, 32'h400), 1);
    cycle(1, 2, mk(HT, 32'h500), 1);
    chk("worm_stall0", 64'(out_valid), 64'h0);
    idle(1);
    idle(1);
    cycle(1, 0, mk(BODY, 32'h401), 1);
    chk("worm_body_vc", 64'(out_vc_id), 64'h0);
    chk("worm_body", 64'(out_fdata), 64'(mk(BODY, 32'h401)));
    cycle(1, 0, mk(TAIL, 32'h402), 1);
    chk("worm_tail", 64'(out_fdata), 64'(mk(TAIL, 32'h402)));
    idle(1);
    chk("worm_vc2", 64'(out_vc_id), 64'h2);
    idle(1);

    // Stability while stalled and a higher VC fills behind.
    cycle(1, 0, mk(HT, 32'h600), 0);
    for (int i = 0; i < 5; i++) begin
      if (i < FIFO_DEPTH) cycle(1, 2, mk(HT, 32'h700 + i), 0);
      else idle(0);
      chk("stable_vc", 64'(out_vc_id), 64'h0);
      chk("stable_data", 64'(out_fdata), 64'(mk(HT, 32'h600)));
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) idle(1);

    // Full VC pushed and popped in the same cycle: push refused.
    for (int i = 0; i < FIFO_DEPTH; i++) cycle(1, 1, mk(HT, 32'h800 + i), 0);
    cycle(1, 1, mk(HT, 32'h8FF), 1);
    chk("fullpop_ovf", 64'(overflow_err), 64'h1);
    chk("fullpop_ready", 64'(in_ready), 64'h7);
    for (int i = 0; i < 3; i++) idle(1);
    chk("fullpop_count3", 64'(out_valid), 64'h0);

    // Reset in the middle of a packet drops the lock and buffered flits.
    cycle(1, 0, mk(HEAD, 32'h900), 1);
    cycle(1, 0, mk(BODY, 32'h901), 0);
    cycle(1, 1, mk(HT, 32'h902), 0);
    do_reset();
    cycle(1, 2, mk(HT, 32'hA01), 1);
    chk("post_rst_vc", 64'(out_vc_id), 64'h2);
    idle(1);
    chk("post_rst_empty", 64'(out_valid), 64'h0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int vc;
      logic [1:0] t;
      if (n % 500 == 499) do_reset();
      vc = ($urandom_range(15) == 0) ? 3 : int'($urandom_range(NUM_VC - 1));
      t  = 2'($urandom_range(3));
      cycle(($urandom_range(9) < 7), vc, mk(t, $urandom()), ($urandom_range(1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Router input stage on the receive side of a link.
- Accepts flits tagged with a virtual-channel (VC) id into one FIFO per VC, with per-VC credit-style ready.
- Presents one flit at a time to the downstream routing/crossbar stage.
- Output uses strict VC priority, with wormhole locking so a packet is never interleaved with another VC's flits.

Parameters:
- NUM_VC, 3, number of virtual channels (>=2).
- FIFO_DEPTH, 4, flits per VC FIFO (power of two, >=2).
- FLIT_W, 34, flit width in bits. Bits [FLIT_W-1:FLIT_W-2] are the flit type; the rest is payload.
- VC_W, derived as max(1, clog2(NUM_VC)); not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream flit valid.
- in_vc_id  in  VC_W  VC of the incoming flit.
- in_fdata  in  FLIT_W  incoming flit.
- in_ready  out  NUM_VC  bit v = VC v FIFO can accept a flit.
- out_valid  out  1  flit presented downstream.
- out_vc_id  out  VC_W  VC of the presented flit.
- out_fdata  out  FLIT_W  presented flit.
- out_ready  in  1  downstream accepts.
- overflow_err  out  1  sticky: a flit was offered to a full VC.

Behaviour:
- Reset (rst high at a clk edge):
  - All FIFOs empty, pointers and counts 0.
  - FSM in IDLE; hold flag cleared.
  - out_valid=0, out_vc_id=0, out_fdata=0, overflow_err=0.
  - in_ready forced to 0 while rst is high; all ones on the first cycle after rst drops.
  - Reset mid-packet discards all buffered flits and any lock.
- Flit types:
  - 00 HEAD: opens a multi-flit packet.
  - 01 BODY.
  - 10 TAIL: closes the packet.
  - 11 HEAD_TAIL: single-flit packet.
- Push:
  - in_ready[v] = !full[v], derived from registered state only (no combinational path from in_valid).
  - Flit written when in_valid && in_ready[in_vc_id].
  - If in_valid && !in_ready[in_vc_id]: flit dropped, overflow_err set to 1 until reset. Out-of-range in_vc_id (>= NUM_VC) is treated the same way.
  - A push into a full FIFO is refused even if that FIFO pops in the same cycle.
- Latency: a flit pushed into an empty VC is first visible on out_* the next cycle. The FIFO is fall-through from its storage; there is no extra output register.
- Push and pop on the same VC in the same cycle: both take effect; count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Selection (FSM IDLE / LOCKED, plus hold flag):
  - IDLE, hold clear: sel = highest-index non-empty VC. out_valid = any VC non-empty.
  - LOCKED: sel = lock_vc. out_valid = !empty[lock_vc]. Higher-priority VCs are stalled even when lock_vc is empty.
  - Hold: if out_valid && !out_ready, sel_q is latched and the hold flag set. Next cycle uses sel_q, so out_vc_id and out_fdata stay stable until the transfer. The flag clears on transfer.
  - out_vc_id = sel; out_fdata = head of FIFO[sel]. When out_valid=0, out_fdata is don't-care and out_vc_id holds its last value.
- Transfer (out_valid && out_ready): pops FIFO[sel]. FSM transitions:
  - IDLE + HEAD: go to LOCKED, lock_vc = sel.
  - IDLE + HEAD_TAIL or BODY or TAIL: stay IDLE. A stray BODY/TAIL is forwarded unchanged; no error.
  - LOCKED + TAIL: go to IDLE.
  - LOCKED + HEAD or HEAD_TAIL: stay LOCKED. Forwarded; the upstream guarantees this does not occur.
- out_valid never depends combinationally on out_ready.

Test Plan:
- Reset release → in_ready=3'b111, out_valid=0. Push HEAD_TAIL 0x3_0000_0001 on VC1 → next cycle out_valid=1, out_vc_id=1, out_fdata=0x3_0000_0001. Pop → out_valid=0.
- Fill VC0 with 4 flits while out_ready=0 → in_ready[0]=0 after the 4th. A 5th push on VC0 → dropped, overflow_err=1 and stays 1. VC0 contents unchanged, drained in order.
- Priority: VC0 and VC2 each hold HEAD_TAIL, out_ready=1 → VC2 flit out first, then VC0.
- Wormhole lock: VC0 HEAD accepted; VC2 then receives HEAD_TAIL; VC0 BODY arrives 3 cycles later → output stays on VC0 (out_valid=0 while VC0 is empty). VC0 BODY, then TAIL, then the VC2 flit.
- Stability: out_valid=1 on VC0, out_ready=0 for 5 cycles while VC2 is filled → out_vc_id=0 and out_fdata unchanged until out_ready=1.
- Full VC pushed and popped in the same cycle → push refused, count 3. rst asserted mid-packet → the next cycle shows empty FIFOs, IDLE, overflow_err=0.
